// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: control tokens used by both encoder and decoder, alignment FSM states.
// Pure declarations; no latency or flow control.
package hdmi_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  function automatic logic is_ctrl_token(input logic [9:0] sym);
    return (sym == CTRL_TOKEN_00) || (sym == CTRL_TOKEN_01) ||
           (sym == CTRL_TOKEN_10) || (sym == CTRL_TOKEN_11);
  endfunction

  // Returns {C1, C0} = {v_sync, h_sync} for a control token.
  function automatic logic [1:0] ctrl_bits(input logic [9:0] sym);
    logic [1:0] c;
    c = 2'b00;
    case (sym)
      CTRL_TOKEN_01: c = 2'b01;
      CTRL_TOKEN_10: c = 2'b10;
      CTRL_TOKEN_11: c = 2'b11;
      default:       c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_tmds_decode_if.sv
// TMDS channel bus: 10-bit symbol in, decoded video/control and alignment status out.
// Streaming, one symbol per clock; no backpressure.
interface hdmi_tmds_decode_if;
  logic [9:0] data_in;
  logic [7:0] data_out;
  logic       active;
  logic       h_sync;
  logic       v_sync;
  logic       locked;
  logic       bitslip;

  modport master (
    output data_in,
    input  data_out, active, h_sync, v_sync, locked, bitslip
  );

  modport slave (
    input  data_in,
    output data_out, active, h_sync, v_sync, locked, bitslip
  );
endinterface

// File: rtl/hdmi_tmds_align.sv
// Word-alignment FSM: counts control-token runs, requests bit slips while searching, drops lock on silence.
// locked/bitslip are registered one edge after the qualifying run or expiry; no backpressure.
module hdmi_tmds_align
  import hdmi_pkg::*;
#(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_HOLD     = 16,
  parameter int LOSS_WINDOW   = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic is_ctrl,
  output logic locked,
  output logic bitslip
);

  // The run counter must be able to hold CTRL_RUN itself to saturate there.
  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WD_MAX = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
  localparam int WD_W   = (WD_MAX > 2) ? $clog2(WD_MAX) : 1;
  localparam int HOLD_W = (SLIP_HOLD > 2) ? $clog2(SLIP_HOLD) : 1;

  localparam logic [RUN_W-1:0]  RUN_FULL    = RUN_W'(CTRL_RUN);
  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(CTRL_RUN - 1);
  localparam logic [WD_W-1:0]   SEARCH_LAST = WD_W'(SEARCH_WINDOW - 1);
  localparam logic [WD_W-1:0]   LOSS_LAST   = WD_W'(LOSS_WINDOW - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(SLIP_HOLD - 1);

  align_state_t      state, state_nxt;
  logic [RUN_W-1:0]  run_cnt;
  logic [WD_W-1:0]   wd, wd_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              slip_nxt;
  logic              run_hit;

  // Only the transition into a full run counts, so a long blanking period yields one hit.
  assign run_hit = is_ctrl && (state != SLIP) && (run_cnt == RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset || state == SLIP || !is_ctrl) begin
      run_cnt <= '0;
    end else if (run_cnt != RUN_FULL) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    wd_nxt    = wd + WD_W'(1);
    hold_nxt  = '0;
    slip_nxt  = 1'b0;
    case (state)
      SEARCH: begin
        if (run_hit) begin
          state_nxt = LOCKED;
          wd_nxt    = '0;
        end else if (wd == SEARCH_LAST) begin
          state_nxt = SLIP;
          wd_nxt    = '0;
          slip_nxt  = 1'b1;
        end
      end
      SLIP: begin
        wd_nxt   = '0;
        hold_nxt = hold + HOLD_W'(1);
        if (hold == HOLD_LAST) begin
          state_nxt = SEARCH;
          hold_nxt  = '0;
        end
      end
      LOCKED: begin
        // A run completing on the expiry cycle keeps the lock.
        if (run_hit) begin
          wd_nxt = '0;
        end else if (wd == LOSS_LAST) begin
          state_nxt = SEARCH;
          wd_nxt    = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        wd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEARCH;
      wd      <= '0;
      hold    <= '0;
      bitslip <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_nxt;
      wd      <= wd_nxt;
      hold    <= hold_nxt;
      bitslip <= slip_nxt;
      locked  <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: rtl/hdmi_tmds_decode.sv
// TMDS receive decoder: control tokens to h/v sync, data symbols to bytes, plus word alignment.
// Two-cycle decode latency (input register + output register); streaming, no backpressure.
module hdmi_tmds_decode
  import hdmi_pkg::*;
#(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_HOLD     = 16,
  parameter int LOSS_WINDOW   = 1048576
) (
  input logic               clk,
  input logic               reset,
  hdmi_tmds_decode_if.slave bus
);

  logic [9:0] sym_q;
  logic       sym_vld;
  logic       is_ctrl;
  logic [7:0] d;
  logic [7:0] dec;
  logic [7:0] data_q;
  logic       active_q;
  logic       h_sync_q;
  logic       v_sync_q;

  // sym_vld keeps the reset contents of sym_q from being decoded or counted as a token.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q   <= '0;
      sym_vld <= 1'b0;
    end else begin
      sym_q   <= bus.data_in;
      sym_vld <= 1'b1;
    end
  end

  assign is_ctrl = sym_vld && is_ctrl_token(sym_q);
  assign d       = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];

  always_comb begin
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      active_q <= 1'b0;
      h_sync_q <= 1'b0;
      v_sync_q <= 1'b0;
    end else if (sym_vld) begin
      if (is_ctrl) begin
        active_q             <= 1'b0;
        {v_sync_q, h_sync_q} <= ctrl_bits(sym_q);
      end else begin
        active_q <= 1'b1;
        data_q   <= dec;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.active   = active_q;
  assign bus.h_sync   = h_sync_q;
  assign bus.v_sync   = v_sync_q;

  hdmi_tmds_align #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_HOLD     (SLIP_HOLD),
    .LOSS_WINDOW   (LOSS_WINDOW)
  ) u_align (
    .clk     (clk),
    .reset   (reset),
    .is_ctrl (is_ctrl),
    .locked  (bus.locked),
    .bitslip (bus.bitslip)
  );

endmodule

// File: tb/tb_hdmi_tmds_decode.sv
// Directed bench for hdmi_tmds_decode with short alignment windows (search 32, hold 4, loss 64).
module tb_hdmi_tmds_decode;

  localparam logic [9:0] TOK00    = 10'b1101010100;
  localparam logic [9:0] TOK01    = 10'b0010101011;
  localparam logic [9:0] TOK10    = 10'b0101010100;
  localparam logic [9:0] TOK11    = 10'b1010101011;
  localparam logic [9:0] DATA_SYM = 10'b1000000000; // decodes to 0xFF

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  hdmi_tmds_decode_if bus ();

  hdmi_tmds_decode #(
    .CTRL_RUN      (8),
    .SEARCH_WINDOW (32),
    .SLIP_HOLD     (4),
    .LOSS_WINDOW   (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sym;
    logic       act;
    logic [7:0] dat;
    logic       vs;
    logic       hs;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.data_in = DATA_SYM;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference TMDS encoder; inv selects the inverted (bit 9 set) form.
  function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic inv);
    int n1;
    logic [8:0] qm;
    n1    = $countones(b);
    qm    = '0;
    qm[0] = b[0];
    if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
      qm[8] = 1'b1;
    end
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
  endfunction

  // Drives 8 tokens, then expects locked low one edge later and high the edge after.
  task automatic lock_sequence(input string tag);
    for (int k = 0; k < 8; k++) begin
      bus.data_in = TOK00;
      tick();
    end
    check({tag, "_lock_early"}, 32'(bus.locked), 32'd0);
    bus.data_in = DATA_SYM;
    tick();
    check({tag, "_lock_rise"}, 32'(bus.locked), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int cnt;
    int nhigh;
    int last;
    int nrise;
    logic prev;
    logic seen;

    vecs[0] = '{TOK00,          1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{TOK01,          1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{TOK10,          1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{TOK11,          1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{10'b0100000000, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{10'b1000000000, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{10'b1111111111, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{10'b0100000001, 1'b1, 8'h03, 1'b1, 1'b1};
    vecs[8] = '{TOK01,          1'b0, 8'h03, 1'b0, 1'b1};
    vecs[9] = '{10'b0000000000, 1'b1, 8'hFE, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_active",   32'(bus.active),   32'd0);
    check("rst_h_sync",   32'(bus.h_sync),   32'd0);
    check("rst_v_sync",   32'(bus.v_sync),   32'd0);
    check("rst_locked",   32'(bus.locked),   32'd0);
    check("rst_bitslip",  32'(bus.bitslip),  32'd0);

    // Token and data decode table, two edges after each input
    foreach (vecs[i]) begin
      bus.data_in = vecs[i].sym;
      tick();
      tick();
      check($sformatf("vec%0d", i),
            32'({bus.active, bus.data_out, bus.v_sync, bus.h_sync}),
            32'({vecs[i].act, vecs[i].dat, vecs[i].vs, vecs[i].hs}));
    end

    // Encoder round trip over all bytes, streamed back to back
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) bus.data_in = tmds_enc(8'(i), 1'($urandom_range(0, 1)));
      tick();
      if (i >= 1) begin
        check($sformatf("roundtrip_%0d", i - 1),
              32'({bus.active, bus.data_out}), 32'({1'b1, 8'(i - 1)}));
      end
    end

    // Lock after exactly 8 tokens
    do_reset();
    lock_sequence("lock8");

    // A data symbol after 7 tokens restarts the run
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.data_in = TOK00;
      tick();
    end
    bus.data_in = DATA_SYM;
    tick();
    lock_sequence("lock_broken");

    // Slip cadence with data only
    do_reset();
    nhigh = 0; nrise = 0; last = 0; prev = 1'b0; seen = 1'b0;
    for (int k = 1; k <= 190; k++) begin
      bus.data_in = tmds_enc(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
      if (bus.locked) seen = 1'b1;
      if (bus.bitslip) nhigh++;
      if (bus.bitslip && !prev) begin
        if (nrise == 0) check("slip_first", 32'(k), 32'd32);
        else            check("slip_gap", 32'(k - last), 32'd36);
        last = k;
        nrise++;
      end
      prev = bus.bitslip;
    end
    check("slip_pulses", 32'(nrise), 32'd5);
    check("slip_high_cycles", 32'(nhigh), 32'd5);
    check("slip_no_lock", 32'(seen), 32'd0);

    // Lock loss after 64 silent cycles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.data_in = TOK00;
      tick();
    end
    bus.data_in = DATA_SYM;
    cnt = 0;
    while (!bus.locked && cnt < 10) begin
      tick();
      cnt++;
    end
    check("loss_locked", 32'(bus.locked), 32'd1);
    cnt = 0; seen = 1'b0;
    while (bus.locked && cnt < 200) begin
      if (bus.bitslip) seen = 1'b1;
      cnt++;
      tick();
    end
    check("loss_len", 32'(cnt), 32'd64);
    check("loss_no_slip", 32'(seen), 32'd0);

    // run_hit on the expiry cycle keeps lock for another full window
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.data_in = TOK00;
      tick();
    end
    bus.data_in = DATA_SYM;
    cnt = 0;
    while (!bus.locked && cnt < 10) begin
      tick();
      cnt++;
    end
    check("race_locked", 32'(bus.locked), 32'd1);
    seen = 1'b0;
    for (int j = 0; j < 63; j++) begin
      bus.data_in = (j >= 55) ? TOK00 : DATA_SYM;
      if (bus.bitslip) seen = 1'b1;
      tick();
    end
    bus.data_in = DATA_SYM;
    cnt = 63;
    while (bus.locked && cnt < 300) begin
      if (bus.bitslip) seen = 1'b1;
      cnt++;
      tick();
    end
    check("race_len", 32'(cnt), 32'd128);
    check("race_no_slip", 32'(seen), 32'd0);

    // Reset during SLIP
    do_reset();
    cnt = 0;
    while (!bus.bitslip && cnt < 100) begin
      tick();
      cnt++;
    end
    check("mid_slip_pulse", 32'(bus.bitslip), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("mslip_data_out", 32'(bus.data_out), 32'd0);
    check("mslip_active",   32'(bus.active),   32'd0);
    check("mslip_h_sync",   32'(bus.h_sync),   32'd0);
    check("mslip_v_sync",   32'(bus.v_sync),   32'd0);
    check("mslip_locked",   32'(bus.locked),   32'd0);
    check("mslip_bitslip",  32'(bus.bitslip),  32'd0);
    reset = 1'b0;
    lock_sequence("mslip");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_tmds_decode.md
# hdmi_tmds_decode

Receive-side counterpart of the HDMI TMDS encoder. Takes one 10-bit TMDS symbol per pixel clock from a deserializer channel, decodes control-period tokens and video-data symbols back to active/h_sync/v_sync/8-bit data, and runs a word-alignment state machine. The state machine requests deserializer bit slips until control-token runs are seen, then reports lock. One instance sits behind each of the three TMDS channel deserializers in the HDMI capture path.

## Interface
- CTRL_RUN, 8: consecutive control tokens required to declare alignment.
- SEARCH_WINDOW, 4096: cycles allowed in SEARCH without a qualifying run before a bit slip is requested.
- SLIP_HOLD, 16: cycles ignored after a bit slip while the deserializer settles.
- LOSS_WINDOW, 1048576: cycles allowed in LOCKED without a qualifying run before lock is dropped.
- clk  in  1  pixel clock; one clock domain, all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- data_in  in  10  TMDS symbol; bit 0 is transmitted first.
- data_out  out  8  decoded video byte; holds the last data value while active=0.
- active  out  1  1 = video-data symbol, 0 = control token.
- h_sync  out  1  decoded control bit C0; holds its value while active=1.
- v_sync  out  1  decoded control bit C1; holds its value while active=1.
- locked  out  1  word alignment established.
- bitslip  out  1  single-cycle request to the deserializer to shift word alignment by one bit.

## Operation
- **Stage 1:** register data_in into sym_q.
- **Stage 2, control tokens.** Compare sym_q against the four control tokens:
  - 10'b1101010100 gives {v_sync,h_sync}=00.
  - 10'b0010101011 gives 01.
  - 10'b0101010100 gives 10.
  - 10'b1010101011 gives 11.
  - On a match, active<=0 and h_sync/v_sync are updated.
- **Stage 2, data symbols.** Any other symbol sets active<=1 and decodes as follows:
  - d = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0].
  - D[0] = d[0].
  - For i = 1..7: D[i] = d[i] ^ d[i-1] if sym_q[8] = 1, otherwise ~(d[i] ^ d[i-1]).
  - data_out <= D.
- No disparity or symbol-validity checking is performed. TERC4 and guard-band symbols decode as data.
- Decoding runs regardless of locked; downstream logic gates on locked.
- **Run counter.** Increments when sym_q is a control token and clears on any other symbol. It saturates at CTRL_RUN.
- **run_hit.** Asserted when the run counter transitions to CTRL_RUN.
- **Alignment FSM, SEARCH:**
  - Watchdog increments every cycle.
  - If run_hit: go to LOCKED and clear the watchdog.
  - Else, if the watchdog reaches SEARCH_WINDOW-1: pulse bitslip for one cycle and go to SLIP.
- **Alignment FSM, SLIP:**
  - Hold counter runs SLIP_HOLD cycles; the run counter is held at 0.
  - Then go to SEARCH with the watchdog cleared.
- **Alignment FSM, LOCKED:**
  - locked=1. Watchdog clears on each run_hit.
  - If the watchdog reaches LOSS_WINDOW-1: go to SEARCH with locked=0; no slip is issued on this transition.
- Simultaneous run_hit and watchdog expiry: run_hit wins. No slip and no lock loss.
- Counter widths are $clog2 of the corresponding parameter. Counters must not wrap; each clears on its state transition.

## Timing
- Reset values: data_out=0, active=0, h_sync=0, v_sync=0, locked=0, bitslip=0, FSM=SEARCH, all counters=0.
- Reset asserted mid-operation returns everything to these values on the next edge, including during SLIP.
- Decode latency: data_in at edge N appears on data_out/active/h_sync/v_sync after edge N+2.
- Lock latency: locked rises at edge N+2 when the CTRL_RUN-th consecutive token is presented at edge N.
- bitslip:
  - High exactly one cycle.
  - Registered output.
  - Minimum spacing is SEARCH_WINDOW+SLIP_HOLD cycles.
- Lock loss: locked falls on the edge after watchdog expiry.

## Structure
- Shared package hdmi_pkg holds:
  - the four control-token constants (CTRL_TOKEN_00/01/10/11), which the encoder also uses;
  - the alignment state enum {SEARCH, SLIP, LOCKED}.
- Natural sub-module hdmi_tmds_align contains the run counter, watchdog, hold counter and FSM. Its inputs are clk, reset and is_ctrl; its outputs are locked and bitslip.
- Decode datapath stays in hdmi_tmds_decode.

## Test plan
- **Control tokens.** Drive 10'b1101010100, 0010101011, 0101010100, 1010101011 in turn. Expect active=0 and {v_sync,h_sync}=00, 01, 10, 11, each two cycles after its input.
- **Data decode.** Drive 10'b0100000000, then 10'b1000000000, then 10'b1111111111. Expect active=1 and data_out = 0x00, 0xFF, 0x00. Loop the encoder output for all 256 bytes with random disparity and require round-trip equality.
- **Lock.** After reset, drive 8 × 10'b1101010100. locked rises 2 cycles after the 8th token. A single data symbol after 7 tokens delays lock by a further 8 tokens.
- **Slip.** With SEARCH_WINDOW=32 and SLIP_HOLD=4, drive random data symbols only. Expect a 1-cycle bitslip every 36 cycles and locked stays 0.
- **Loss and contention.** With LOSS_WINDOW=64: after lock, drive only data symbols and expect locked to fall after 64 cycles. In a separate run, place run_hit on the expiry cycle and expect locked to remain 1.
- **Reset mid-SLIP.** Assert reset during SLIP. Expect all outputs at their reset values the next cycle, and a fresh lock sequence succeeds.
